// File: rtl/mcpu_ctrl_fsm.sv
// mcpu_ctrl_fsm: multi-cycle RV32I-subset control unit.
// Sequences a shared-ALU, single-memory datapath one state per clock and
// drives its mux selects, write enables and the MIO request handshake.
// Optional feature macro: MCPU_INSTRET_EN enables the retired-instruction
// counter on the instret port; without it instret is tied to zero.
module mcpu_ctrl_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  OPcode,
    input  logic [2:0]  Fun3,
    input  logic        Fun7,
    input  logic        zero,
    input  logic        MIO_ready,
    output logic        CPU_MIO,
    output logic        MemRW,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [1:0]  PCSource,
    output logic        RegWrite,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrc_A,
    output logic [1:0]  ALUSrc_B,
    output logic [3:0]  ALU_Control,
    output logic [2:0]  ImmSel,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_EXR  = 4'd2,
        S_EXI  = 4'd3,
        S_MA   = 4'd4,
        S_MR   = 4'd5,
        S_MW   = 4'd6,
        S_WB   = 4'd7,
        S_WBM  = 4'd8,
        S_BR   = 4'd9,
        S_JAL  = 4'd10,
        S_JALR = 4'd11,
        S_LUI  = 4'd12,
        S_ERR  = 4'd15
    } state_t;

    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_I     = 5'b00100;
    localparam logic [4:0] OP_LD    = 5'b00000;
    localparam logic [4:0] OP_ST    = 5'b01000;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SLL  = 4'b1110;
    localparam logic [3:0] ALU_SRA  = 4'b1111;

    localparam logic [2:0] IMM_U = 3'b000;
    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // R-type operation decode: {legal, alu_op}; illegal combinations return 0.
    function automatic logic [4:0] r_alu(input logic [2:0] f3, input logic f7);
        case ({f3, f7})
            4'b0000: r_alu = {1'b1, ALU_ADD};
            4'b0001: r_alu = {1'b1, ALU_SUB};
            4'b0010: r_alu = {1'b1, ALU_SLL};
            4'b0100: r_alu = {1'b1, ALU_SLT};
            4'b0110: r_alu = {1'b1, ALU_SLTU};
            4'b1000: r_alu = {1'b1, ALU_XOR};
            4'b1010: r_alu = {1'b1, ALU_SRL};
            4'b1011: r_alu = {1'b1, ALU_SRA};
            4'b1100: r_alu = {1'b1, ALU_OR};
            4'b1110: r_alu = {1'b1, ALU_AND};
            default: r_alu = 5'b0_0000;
        endcase
    endfunction

    // I-type ALU operation decode; Fun7 only distinguishes srli from srai.
    function automatic logic [3:0] i_alu(input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  i_alu = ALU_ADD;
            3'b001:  i_alu = ALU_SLL;
            3'b010:  i_alu = ALU_SLT;
            3'b011:  i_alu = ALU_SLTU;
            3'b100:  i_alu = ALU_XOR;
            3'b101:  i_alu = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  i_alu = ALU_OR;
            default: i_alu = ALU_AND;
        endcase
    endfunction

    // Immediate format needed while the ID state computes OldPC+imm.
    function automatic logic [2:0] id_imm(input logic [4:0] op);
        case (op)
            OP_BR:            id_imm = IMM_B;
            OP_JAL:           id_imm = IMM_J;
            OP_AUIPC, OP_LUI: id_imm = IMM_U;
            default:          id_imm = IMM_I;
        endcase
    endfunction

    state_t state_q;
    state_t state_d;
    logic   mio_go;
    logic   exr_ok;
    logic [3:0] exr_op;

    // A completed memory access only counts while reset is released, so no
    // PC/IR write is requested once rstn has fallen.
    assign mio_go           = MIO_ready & rstn;
    assign {exr_ok, exr_op} = r_alu(Fun3, Fun7);

    // State register, asynchronously forced to the fetch state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; everything defaults to inactive.
    always_comb begin
        state_d     = state_q;
        CPU_MIO     = 1'b0;
        MemRW       = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCSource    = 2'b00;
        RegWrite    = 1'b0;
        MemtoReg    = 2'b00;
        ALUSrc_A    = 2'b00;
        ALUSrc_B    = 2'b00;
        ALU_Control = 4'b0000;
        ImmSel      = 3'b000;
        case (state_q)
            S_IF: begin
                CPU_MIO     = 1'b1;
                ALUSrc_B    = 2'b01;
                ALU_Control = ALU_ADD;
                IRWrite     = mio_go;
                PCWrite     = mio_go;
                if (mio_go) begin
                    state_d = S_ID;
                end
            end
            S_ID: begin
                ALUSrc_A    = 2'b10;
                ALUSrc_B    = 2'b10;
                ALU_Control = ALU_ADD;
                ImmSel      = id_imm(OPcode);
                case (OPcode)
                    OP_R:         state_d = S_EXR;
                    OP_I:         state_d = S_EXI;
                    OP_LD, OP_ST: state_d = S_MA;
                    OP_BR:        state_d = S_BR;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
                    OP_AUIPC:     state_d = S_WB;
                    default:      state_d = S_ERR;
                endcase
            end
            S_EXR: begin
                ALUSrc_A    = 2'b01;
                ALUSrc_B    = 2'b00;
                ALU_Control = exr_op;
                state_d     = exr_ok ? S_WB : S_ERR;
            end
            S_EXI: begin
                ALUSrc_A    = 2'b01;
                ALUSrc_B    = 2'b10;
                ImmSel      = IMM_I;
                ALU_Control = i_alu(Fun3, Fun7);
                state_d     = S_WB;
            end
            S_MA: begin
                ALUSrc_A    = 2'b01;
                ALUSrc_B    = 2'b10;
                ALU_Control = ALU_ADD;
                ImmSel      = (OPcode == OP_ST) ? IMM_S : IMM_I;
                if (OPcode == OP_LD) begin
                    state_d = S_MR;
                end else if (OPcode == OP_ST) begin
                    state_d = S_MW;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_MR: begin
                CPU_MIO = 1'b1;
                IorD    = 1'b1;
                if (mio_go) begin
                    state_d = S_WBM;
                end
            end
            S_MW: begin
                CPU_MIO = 1'b1;
                IorD    = 1'b1;
                MemRW   = 1'b1;
                if (mio_go) begin
                    state_d = S_IF;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b00;
                state_d  = S_IF;
            end
            S_WBM: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                state_d  = S_IF;
            end
            S_BR: begin
                ALUSrc_A    = 2'b01;
                ALUSrc_B    = 2'b00;
                ALU_Control = ALU_SUB;
                PCSource    = 2'b01;
                case (Fun3)
                    3'b000: begin
                        PCWrite = zero;
                        state_d = S_IF;
                    end
                    3'b001: begin
                        PCWrite = ~zero;
                        state_d = S_IF;
                    end
                    default: state_d = S_ERR;
                endcase
            end
            S_JAL: begin
                // PC was already advanced to PC+4 in IF, so it is the link value.
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
                PCWrite  = 1'b1;
                PCSource = 2'b01;
                state_d  = S_IF;
            end
            S_JALR: begin
                // Link write and PC load share one edge; the register file
                // therefore still sees the old PC+4.
                ALUSrc_A    = 2'b01;
                ALUSrc_B    = 2'b10;
                ALU_Control = ALU_ADD;
                ImmSel      = IMM_I;
                PCSource    = 2'b00;
                PCWrite     = 1'b1;
                RegWrite    = 1'b1;
                MemtoReg    = 2'b10;
                state_d     = S_IF;
            end
            S_LUI: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b11;
                ImmSel   = IMM_U;
                state_d  = S_IF;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    assign illegal = (state_q == S_ERR);
    assign state   = state_q;

`ifdef MCPU_INSTRET_EN
    logic [31:0] instret_q;
    logic        retire;

    // An instruction retires when any execution state hands back to fetch.
    assign retire = (state_q != S_IF) && (state_q != S_ERR) && (state_d == S_IF);

    // Retired-instruction counter, free-running wrap at 2^32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instret_q <= 32'h0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 32'h0;
`endif

endmodule
